// File: rtl/branch_ctrl.sv
// branch_ctrl
// ----------------------------------------------------------------------------
// Resolves conditional branches and JAL/JALR in EX and owns the fetch PC.
// A redirect loads the computed target into pc, then holds flush high for
// FLUSH_CYCLES unstalled cycles so IF/ID can discard the wrong-path fetches.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   stall      in   hold fetch; pc and the flush counter freeze
//   br_en      in   conditional branch in EX
//   cmp_b      in   comparator result for the EX branch
//   jal        in   JAL in EX
//   jalr       in   JALR in EX (wins over jal when both are set)
//   pc_ex      in   PC of the EX instruction
//   rs1_d      in   rs1 value, JALR base
//   imm        in   sign-extended offset
//   pc         out  fetch address (registered)
//   flush      out  kill IF/ID contents (registered)
//   link_d     out  pc_ex + 4 (combinational), rd value for JAL/JALR
//   misalign   out  one-cycle pulse: accepted redirect target had bit 1 set
//   taken_cnt  out  saturating count of accepted redirects
//   dbg_state  out  FSM state for observation: 0 = RUN, 1 = FLUSH
//
// Parameters
//   XLEN          data/address width
//   RESET_PC      fetch address after reset
//   FLUSH_CYCLES  cycles flush stays high after a redirect, legal 1..7
// ----------------------------------------------------------------------------
module branch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_en,
  input  logic            cmp_b,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] rs1_d,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic [XLEN-1:0] link_d,
  output logic            misalign,
  output logic [15:0]     taken_cnt,
  output logic            dbg_state
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // fcnt counts the remaining extra flush cycles, so it starts one below
  // FLUSH_CYCLES and the FSM leaves FLUSH on the unstalled cycle where it is 0.
  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  logic [2:0]      fcnt;
  logic            req;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next_seq;

  // A branch whose comparator says "not taken" is not a redirect.
  assign req = jalr | jal | (br_en & cmp_b);

  // JALR clears bit 0 of its sum; JALR wins when jal and jalr are both set.
  assign jalr_sum = rs1_d + imm;
  assign target   = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_ex + imm);

  assign pc_next_seq = pc + PC_STEP;
  assign link_d      = pc_ex + PC_STEP;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fcnt      <= '0;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      misalign  <= 1'b0;
      taken_cnt <= '0;
    end else begin
      // misalign is a pulse: cleared on every edge without an accepted redirect
      misalign <= 1'b0;
      case (state)
        RUN: begin
          if (req) begin
            // A redirect is accepted even while stalled: the stalled fetch
            // is on the wrong path anyway.
            pc       <= target;
            flush    <= 1'b1;
            fcnt     <= FCNT_INIT;
            state    <= FLUSH;
            misalign <= target[1];
            if (taken_cnt != 16'hFFFF) begin
              taken_cnt <= taken_cnt + 16'd1;
            end
          end else begin
            flush <= 1'b0;
            if (!stall) begin
              pc <= pc_next_seq;
            end
          end
        end
        FLUSH: begin
          // EX holds a flushed bubble here, so req is ignored.
          if (!stall) begin
            pc <= pc_next_seq;
            if (fcnt == 3'd0) begin
              flush <= 1'b0;
              state <= RUN;
            end else begin
              fcnt <= fcnt - 3'd1;
            end
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_en, cmp_b, jal, jalr;
  logic [31:0] pc_ex, rs1_d, imm;
  logic [31:0] pc, link_d;
  logic        flush, misalign, dbg_state;
  logic [15:0] taken_cnt;

  always #5 clk = ~clk;

  branch_ctrl #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_en(br_en), .cmp_b(cmp_b),
    .jal(jal), .jalr(jalr), .pc_ex(pc_ex), .rs1_d(rs1_d), .imm(imm),
    .pc(pc), .flush(flush), .link_d(link_d), .misalign(misalign),
    .taken_cnt(taken_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the fetch address, how many flush cycles are still owed, the
  // redirect count and the misalign pulse, straight from the rules.
  logic [31:0] m_pc;
  int          m_left;
  int          m_cnt;
  logic        m_mis;

  task automatic model_reset();
    m_pc = RESET_PC; m_left = 0; m_cnt = 0; m_mis = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] t;
    logic        r;
    r = jal | jalr | (br_en & cmp_b);
    m_mis = 1'b0;
    if (m_left == 0) begin
      if (r) begin
        if (jalr) t = (rs1_d + imm) & 32'hFFFF_FFFE;
        else      t = pc_ex + imm;
        m_pc   = t;
        m_left = FLUSH_CYCLES;
        if (m_cnt < 65535) m_cnt++;
        m_mis  = t[1];
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
      m_left--;
    end
    exp_q.push_back(m_pc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic be, input logic cb, input logic j,
                       input logic jr, input logic [31:0] pe, input logic [31:0] r1,
                       input logic [31:0] im);
    stall = s; br_en = be; cmp_b = cb; jal = j; jalr = jr;
    pc_ex = pe; rs1_d = r1; imm = im;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // One clock: check link_d before the edge, update the model at the edge,
  // compare all registered outputs on the following falling edge.
  task automatic cycle(input string tag);
    logic [31:0] e;
    #1;
    check({tag, ".link_d"}, link_d, pc_ex + 32'd4);
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".pc"}, pc, e);
    check({tag, ".flush"}, {31'b0, flush}, {31'b0, m_left > 0});
    check({tag, ".state"}, {31'b0, dbg_state}, {31'b0, m_left > 0});
    check({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
    check({tag, ".taken_cnt"}, {16'b0, taken_cnt}, m_cnt[31:0]);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        stall, br_en, cmp_b, jal, jalr;
    logic [31:0] pc_ex, rs1_d, imm;
    logic [31:0] exp_pc;
    logic        exp_flush, exp_mis;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic s, input logic be, input logic cb,
                              input logic j, input logic jr, input logic [31:0] pe,
                              input logic [31:0] r1, input logic [31:0] im,
                              input logic [31:0] epc, input logic efl,
                              input logic emi, input logic [15:0] ecnt);
    vec_t v;
    v.stall = s; v.br_en = be; v.cmp_b = cb; v.jal = j; v.jalr = jr;
    v.pc_ex = pe; v.rs1_d = r1; v.imm = im;
    v.exp_pc = epc; v.exp_flush = efl; v.exp_mis = emi; v.exp_cnt = ecnt;
    return v;
  endfunction

  initial begin
    //            st br cb jal jr  pc_ex      rs1_d      imm          pc          fl mi cnt
    vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h004, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h008, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h00C, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 0, 32'h100,   32'h0,     32'h40,    32'h140, 1, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h144, 1, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h148, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h14C, 0, 0, 1);
    vecs[7]  = mk(0, 1, 0, 0, 0, 32'h100,   32'h0,     32'h40,    32'h150, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 1, 32'h0,     32'h203,   32'h0,     32'h202, 1, 1, 2);
    vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h206, 1, 0, 2);
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h20A, 0, 0, 2);
    vecs[11] = mk(0, 0, 0, 1, 1, 32'h10,    32'h300,   32'h4,     32'h304, 1, 0, 3);
    vecs[12] = mk(1, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h304, 1, 0, 3);
    vecs[13] = mk(1, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h304, 1, 0, 3);
    vecs[14] = mk(1, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h304, 1, 0, 3);
    vecs[15] = mk(0, 0, 0, 1, 0, 32'h0,     32'h0,     32'h800,   32'h308, 1, 0, 3);
    vecs[16] = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h30C, 0, 0, 3);
    vecs[17] = mk(1, 0, 0, 1, 0, 32'h400,   32'h0,     32'h10,    32'h410, 1, 0, 4);
    vecs[18] = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h414, 1, 0, 4);
    vecs[19] = mk(0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h418, 0, 0, 4);
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.pc", pc, RESET_PC);
    check("reset.flush", {31'b0, flush}, 32'd0);
    check("reset.taken_cnt", {16'b0, taken_cnt}, 32'd0);
    check("reset.misalign", {31'b0, misalign}, 32'd0);
    rst_n = 1'b1;

    // Directed table, starting from pc = RESET_PC = 0.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, vecs[i].br_en, vecs[i].cmp_b, vecs[i].jal, vecs[i].jalr,
            vecs[i].pc_ex, vecs[i].rs1_d, vecs[i].imm);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.tbl_flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
      check($sformatf("vec%0d.tbl_mis", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      check($sformatf("vec%0d.tbl_cnt", i), {16'b0, taken_cnt}, {16'b0, vecs[i].exp_cnt});
    end

    // Reset in the middle of a flush: asynchronous, no residual flush.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h20);
    cycle("midflush.redirect");
    idle();
    rst_n = 1'b0;
    #1;
    check("midflush.pc", pc, RESET_PC);
    check("midflush.flush", {31'b0, flush}, 32'd0);
    check("midflush.taken_cnt", {16'b0, taken_cnt}, 32'd0);
    check("midflush.state", {31'b0, dbg_state}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap of pc from 0xFFFF_FFFC to 0, and of link_d.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF00, 32'h0, 32'h0000_00FC);
    cycle("wrap.redirect");
    check("wrap.target", pc, 32'hFFFF_FFFC);
    idle();
    cycle("wrap.step");
    check("wrap.pc_zero", pc, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    #1;
    check("wrap.link_d", link_d, 32'h0);
    cycle("wrap.after");

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        s;
      int unsigned kind;
      s    = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 6);
      case (kind)
        0: drive(s, 1'b1, 1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom);
        1: drive(s, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
        2: drive(s, 1'b0, 1'($urandom), 1'b1, 1'b0, $urandom, $urandom, $urandom);
        3: drive(s, 1'($urandom), 1'($urandom), 1'b0, 1'b1, $urandom, $urandom, $urandom);
        4: drive(s, 1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom, $urandom);
        default: drive(s, 1'b0, 1'($urandom), 1'b0, 1'b0, $urandom, $urandom, $urandom);
      endcase
      cycle("rand");
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Consumer of the comparator flag `b`: resolves conditional branches and jumps in EX and owns the fetch program counter.
- Sits between the comparator/decoder and instruction fetch.
- On a redirect it loads the new target into `pc` and kills the wrong-path instructions behind it with a multi-cycle flush sequence.
- Also exports the link address and a saturating count of taken redirects.

Parameters:
- XLEN, 32, data/address width (matches `REG_LEN`).
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FLUSH_CYCLES, 2, cycles `flush` is held after a redirect; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold fetch; PC and flush counter freeze.
- br_en  input  1  conditional branch in EX.
- cmp_b  input  1  comparator result for the EX branch.
- jal  input  1  JAL in EX.
- jalr  input  1  JALR in EX.
- pc_ex  input  XLEN  PC of the EX instruction.
- rs1_d  input  XLEN  rs1 value (JALR base).
- imm  input  XLEN  sign-extended offset.
- pc  output  XLEN  fetch address (registered).
- flush  output  1  kill IF/ID contents (registered).
- link_d  output  XLEN  pc_ex + 4, combinational, for rd of JAL/JALR.
- misalign  output  1  one-cycle pulse: last redirect target had bit 1 set.
- taken_cnt  output  16  saturating count of accepted redirects.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC, flush = 0, misalign = 0, taken_cnt = 0, state = RUN, fcnt = 0.
  - Reset takes effect mid-flush with no residual flush.
- Redirect request: req = jalr | jal | (br_en & cmp_b). br_en with cmp_b = 0 is not a redirect.
- Target, arithmetic modulo 2^XLEN with no overflow detection:
  - jalr = 1: (rs1_d + imm) & ~1. JALR takes priority if both jal and jalr are set.
  - Otherwise: pc_ex + imm.
- States: RUN and FLUSH.
- RUN with req = 1, accepted even if stall = 1 (redirect beats stall):
  - pc <= target; flush <= 1; fcnt <= FLUSH_CYCLES-1; state <= FLUSH.
  - taken_cnt increments and saturates at 16'hFFFF.
  - misalign <= target[1]; it is 0 on any cycle without an accepted redirect.
- RUN with req = 0:
  - stall = 0: pc <= pc + 4, wrapping from 0xFFFF_FFFC to 0.
  - stall = 1: pc holds.
  - flush = 0.
- FLUSH:
  - req is ignored, because EX holds a flushed bubble.
  - stall = 1: pc, flush and fcnt all hold.
  - stall = 0 and fcnt = 0: flush <= 0, state <= RUN, pc <= pc + 4.
  - stall = 0 and fcnt != 0: fcnt <= fcnt-1, pc <= pc + 4, flush stays 1.
- Timing:
  - With stall = 0, flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect edge.
  - Redirect latency is 1 cycle: target appears on pc one edge after req is sampled.
- link_d is valid every cycle regardless of state; it wraps modulo 2^XLEN.
- With FLUSH_CYCLES = 1, FLUSH lasts one unstalled cycle and the next req is honoured on the following cycle.

Test Plan:
- Reset and sequential fetch: rst_n low then high, no req, stall = 0 for 4 cycles → pc = 0, 4, 8, 12; flush = 0; taken_cnt = 0.
- Taken branch: pc_ex = 0x100, imm = 0x40, br_en = 1, cmp_b = 1 for 1 cycle → next pc = 0x140; flush = 1 for 2 cycles; then pc = 0x144, 0x148, 0x14C; taken_cnt = 1.
- Not-taken branch: br_en = 1, cmp_b = 0 → pc continues +4, flush stays 0, taken_cnt unchanged.
- JALR:
  - Clearing bit 0: rs1_d = 0x203, imm = 0 → pc = 0x202 and misalign = 1 for one cycle.
  - Priority: jal and jalr both set, rs1_d = 0x300, imm = 4, pc_ex = 0x10 → pc = 0x304.
- Stall interactions:
  - stall = 1 with req → redirect still taken.
  - stall held 3 cycles during FLUSH → pc and flush frozen; flush total stays 2 unstalled cycles.
  - req asserted during FLUSH → ignored.
- Reset mid-flush: assert rst_n low the cycle after a redirect → pc = RESET_PC, flush = 0 immediately (async). Also check wrap: pc = 0xFFFF_FFFC → 0.
